demux2_reg_router: RTL
======================

// Module: demux2_reg_router
// PURPOSE
// - Registered 1-to-2 demultiplexer with valid/ready handshakes; the counterpart of the
//   2:1 select muxes in the datapath.
// - Accepts one 32-bit word plus a select bit on a single upstream port.
// - Delivers the word on exactly one of two downstream ports: 0 = data memory path,
//   1 = MMIO path.
// - One-entry pipeline slot gives registered outputs and full throughput when the
//   chosen sink is ready.
// PARAMETERS
// - DATA_W  32  width of in_data / out0_data / out1_data
// - CNT_W   16  width of per-port delivery counters (DEMUX_STATS_EN only)
// PORTS
// - clk        in   1       rising-edge clock, single clock domain
// - reset      in   1       asynchronous, active-high reset
// - in_valid   in   1       upstream word valid
// - in_ready   out  1       block can accept this cycle
// - in_data    in   DATA_W  upstream word
// - in_select  in   1       destination: 0 -> port 0, 1 -> port 1
// - out0_valid out  1       port 0 word valid
// - out0_ready in   1       port 0 sink ready
// - out0_data  out  DATA_W  port 0 word
// - out1_valid out  1       port 1 word valid
// - out1_ready in   1       port 1 sink ready
// - out1_data  out  DATA_W  port 1 word
// - cnt0       out  CNT_W   words delivered on port 0 (DEMUX_STATS_EN only)
// - cnt1       out  CNT_W   words delivered on port 1 (DEMUX_STATS_EN only)
// BEHAVIOUR
// - Reset values (async, immediate): state=EMPTY; out0_valid=out1_valid=0;
//   slot data=0, slot select=0; cnt0=cnt1=0.
// - Transfers: upstream on in_valid&in_ready; port n on outN_valid&outN_ready.
// - FSM states:
//   - EMPTY: in_ready=1. Accept -> FULL; slot captures in_data and in_select.
//   - FULL: slot word drives the port named by the slot select.
//     - Drained with no accept -> EMPTY.
//     - Drained with an accept in the same cycle -> stay FULL, slot reloads.
//     - Not drained -> hold slot unchanged.
// - Port signals:
//   - out0_valid = FULL & !sel; out1_valid = FULL & sel. Never both high.
//   - out0_data and out1_data both carry the slot word; only the valid bit differs.
// - in_ready = EMPTY | (FULL & ready of the selected port).
//   - Combinational from outN_ready only; no path from in_valid.
// - Latency: accept at edge k -> outN_valid high from edge k (registered), visible
//   the cycle after accept.
// - Throughput: 1 word/cycle while the selected sink holds ready=1, including
//   alternating selects.
// - Stall rules:
//   - The unselected port's ready is ignored.
//   - Sinks may assert ready with no valid present.
//   - in_data and in_select are sampled only on accept.
// - Reset mid-operation discards the buffered word; no partial transfer is reported.
// - Protocol: once outN_valid is high, slot word and select stay stable until the
//   transfer completes.
// CONFIGURATION
// - DEMUX_STATS_EN defined:
//   - cnt0/cnt1 increment by 1 on each completed port-0/port-1 transfer.
//   - Wrap modulo 2^CNT_W; no saturation.
//   - Cleared only by reset.
// - DEMUX_STATS_EN undefined:
//   - cnt0/cnt1 ports and counter logic are not present.
//   - All other behaviour identical.
// TESTING
// - Reset with in_valid=1 -> out0_valid=out1_valid=0, in_ready=1, counters 0.
// - Word 0xDEADBEEF sel=0, out0_ready=1 -> out0_valid 1 cycle later with 0xDEADBEEF;
//   out1_valid stays 0.
// - Stream 0x1,0x2,0x3 with sel 1,0,1, both sinks ready -> 1 word/cycle, correct
//   ports, no bubbles.
// - Word 0xA5A5A5A5 sel=1, out1_ready=0 for 5 cycles:
//   - in_ready=0 and data stable throughout.
//   - out0_ready toggling has no effect.
//   - out1_ready=1 -> single transfer.
// - Assert reset while FULL with 0x12345678 pending -> valid drops immediately;
//   word never delivered.
// - DEMUX_STATS_EN, CNT_W=4: 17 port-0 transfers -> cnt0=1 (wrapped), cnt1=0.

Source files
------------

// File: rtl/demux2_reg_router.sv
// ---------------------------------------------------------------------------
// demux2_reg_router
//
// Registered 1-to-2 demultiplexer with valid/ready handshakes. One upstream
// port carries a DATA_W-bit word plus a select bit. A one-entry pipeline slot
// holds the word and presents it on exactly one downstream port:
//   select 0 -> port 0 (data memory path)
//   select 1 -> port 1 (MMIO path)
// While the selected sink holds ready high, the slot drains and refills in
// the same cycle, giving one word per cycle even when selects alternate.
//
// Optional feature macro: DEMUX_STATS_EN
//   When defined, cnt0/cnt1 count completed transfers on port 0/port 1.
//   The counters wrap modulo 2^CNT_W and are cleared only by reset. When
//   the macro is undefined the counter ports and logic are absent.
//
// Parameters:
//   DATA_W  word width of in_data / out0_data / out1_data
//   CNT_W   width of the per-port delivery counters (DEMUX_STATS_EN only)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in_valid    upstream word valid
//   in_ready    block can accept this cycle (depends on outN_ready only)
//   in_data     upstream word
//   in_select   destination select
//   out0_valid  port 0 word valid      out0_ready  port 0 sink ready
//   out0_data   port 0 word
//   out1_valid  port 1 word valid      out1_ready  port 1 sink ready
//   out1_data   port 1 word
//   cnt0, cnt1  delivered-word counters (DEMUX_STATS_EN only)
// ---------------------------------------------------------------------------
module demux2_reg_router #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_select,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                sel_q, sel_d;

  logic                sink_ready_s;  // ready of the port named by the slot
  logic                drain_s;       // slot word leaves this cycle
  logic                in_ready_s;
  logic                accept_s;      // upstream word enters this cycle

  // Handshake decode: in_ready is built from state and sink readies only,
  // so there is no combinational path from in_valid back to in_ready.
  always_comb begin
    sink_ready_s = 1'b0;
    drain_s      = 1'b0;
    in_ready_s   = 1'b0;
    accept_s     = 1'b0;
    if (sel_q) begin
      sink_ready_s = out1_ready;
    end else begin
      sink_ready_s = out0_ready;
    end
    if (state_q == ST_FULL) begin
      drain_s    = sink_ready_s;
      in_ready_s = sink_ready_s;
    end else begin
      drain_s    = 1'b0;
      in_ready_s = 1'b1;
    end
    accept_s = in_valid & in_ready_s;
  end

  // Next-state and slot-load logic: the slot only changes on accept, so the
  // presented word and select stay stable while a sink stalls.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
          data_d  = in_data;
          sel_d   = in_select;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain_s) begin
          if (accept_s) begin
            // Drain and refill in one cycle keeps full throughput.
            state_d = ST_FULL;
            data_d  = in_data;
            sel_d   = in_select;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and slot registers; reset discards any buffered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= {DATA_W{1'b0}};
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign in_ready   = in_ready_s;
  // Valids decode straight from flops, so both ports see registered outputs
  // and at most one of them can be high.
  assign out0_valid = (state_q == ST_FULL) & ~sel_q;
  assign out1_valid = (state_q == ST_FULL) &  sel_q;
  assign out0_data  = data_q;
  assign out1_data  = data_q;

`ifdef DEMUX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Delivery counters advance on each completed port transfer and wrap.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (drain_s) begin
      if (sel_q) begin
        cnt1_d = cnt1_q + CNT_ONE;
      end else begin
        cnt0_d = cnt0_q + CNT_ONE;
      end
    end else begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
